seg_frame_tx: RTL and testbench
===============================

# seg_frame_tx

Serial frame transmitter for the seven-segment clock display link. It takes four hex/BCD digit codes, a colon flag and per-digit blanking, or a raw 32-bit word. It encodes them into the display's 32-bit segment frame and shifts the frame out MSB-first on a three-wire interface (shift clock, data, latch) to the display scanner. It runs on the on-chip oscillator clock and generates the serial clock internally.

## Interface
- CLK_DIV, 4: `osc_clk` cycles per half-period of `ser_clk`; legal range ≥1.
- LATCH_CYC, 4: `osc_clk` cycles that `ser_latch` is held high; legal range ≥1.
- osc_clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  request a frame; sampled only in IDLE.
- digits  in  16  four 4-bit codes; [15:12] is the leftmost digit, [3:0] the rightmost.
- colon  in  1  colon flag; carried in frame bit 31.
- blank_mask  in  4  bit i=1 blanks the digit coded by digits[4i+3:4i].
- raw_mode  in  1  1 = transmit `raw_word` unmodified.
- raw_word  in  32  raw frame.
- ser_clk  out  1  shift clock to the display.
- ser_data  out  1  serial data; the receiver samples it on the `ser_clk` rising edge.
- ser_latch  out  1  the receiver copies its shift register on the rising edge of this signal.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the latch falls.

## Operation
- Segment encoding: bit0=a … bit6=g, active-high.
  - Hex codes 0–F map to 3F,06,5B,4F,66,6D,7D,07,7F,6F,77,7C,39,5E,79,71.
  - A blanked digit encodes as 00.
- Frame word layout: {colon, seg(d3), 0, seg(d2), 0, seg(d1), 0, seg(d0)}.
  - Byte 3 = bits 31:24 carries the leftmost digit.
  - Bits 23, 15 and 7 are 0.
- When `raw_mode` is 1, the frame word is `raw_word`.
- On start accept, the inputs are encoded and captured into a 32-bit shift register in the same edge. Input changes after that edge do not affect the frame.
- FSM states:
  - IDLE: accepts `start`. All outputs are 0.
  - BIT_LO: `ser_clk` low, `ser_data` = current MSB. Lasts CLK_DIV cycles, then goes to BIT_HI.
  - BIT_HI: `ser_clk` high. Lasts CLK_DIV cycles, then the register shifts left by 1.
    - Goes to BIT_LO if bits remain.
    - Goes to GAP after the 32nd bit.
  - GAP: `ser_clk` low, `ser_latch` low. Lasts CLK_DIV cycles, then goes to LATCH.
  - LATCH: `ser_latch` high. Lasts LATCH_CYC cycles, then goes to IDLE.
- Bit counter: 6 bits, counts 0–31. Phase counter: sized for max(CLK_DIV, LATCH_CYC).
- `ser_data` changes only in the cycle in which `ser_clk` goes low (entering BIT_LO). It is stable through each BIT_HI.
- `ser_data` is 0 in IDLE, GAP and LATCH.
- `start` while busy is ignored; no queuing.

## Timing
- All outputs are registered. Reset value of every output is 0; the state after reset is IDLE.
- With start accepted at edge k and D = CLK_DIV:
  - `busy`=1 and `ser_data`=bit31 from k+1.
  - The n-th rise of `ser_clk` (n=0..31, bit 31−n) is at k+1+D+2nD.
  - The last fall of `ser_clk` is at k+1+64D.
  - `ser_latch` rises at k+1+65D and falls at k+1+65D+LATCH_CYC.
- In the cycle `ser_latch` falls, `done`=1 for exactly one cycle and `busy`=0.
- Default frame length: 265 cycles from start accept to `done`.
- `start` high in the `done` cycle is accepted (state is IDLE), giving back-to-back frames with no extra gap.
- Reset low at any edge, mid-frame included:
  - Next cycle: all outputs are 0 and the FSM is IDLE.
  - No latch pulse is issued, so the receiver keeps its previous display.
  - No `done` pulse.

## Test plan
- digits=16'h1234, colon=1, blank_mask=0, raw_mode=0, start pulse -> 32 bits on `ser_clk` rises read 0x865B4F66 MSB-first. One `ser_latch` pulse of 4 cycles follows, and `done` occurs at k+265.
- digits=16'h0905, colon=0, blank_mask=4'b1000 -> captured word 0x006F3F6D. A bench receiver (shift on `ser_clk`, copy on `ser_latch`) holds 0x006F3F6D.
- raw_mode=1, raw_word=0xA5A5A5A5. Inputs are changed every cycle after accept -> word received is 0xA5A5A5A5. `ser_data` is never observed changing while `ser_clk` is high.
- `start` held high continuously for 3 frames with digits changing between frames -> `busy` drops for only the `done` cycle. Three latches occur 265 cycles apart, each carrying the digits present at its own accept edge.
- rst_n low for 1 cycle after the 10th `ser_clk` rise -> outputs are 0 the next cycle. No `ser_latch` or `done` occurs. A subsequent start yields a correct full frame.
- `start` pulsed mid-frame (cycle k+100) -> ignored. Exactly one frame and one `done`.

Source files
------------

// File: rtl/seg_frame_tx.sv
// Encodes four hex digits (or a raw word) into a 32-bit segment frame and shifts it out MSB-first with a latch strobe.
// Frame takes 1+65*CLK_DIV+LATCH_CYC cycles from accept to done; start is ignored while busy (no queuing).
module seg_frame_tx #(
  parameter int CLK_DIV   = 4,
  parameter int LATCH_CYC = 4
) (
  input  logic        osc_clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] digits,
  input  logic        colon,
  input  logic [3:0]  blank_mask,
  input  logic        raw_mode,
  input  logic [31:0] raw_word,
  output logic        ser_clk,
  output logic        ser_data,
  output logic        ser_latch,
  output logic        busy,
  output logic        done
);

  localparam int PH_MAX = (CLK_DIV > LATCH_CYC) ? CLK_DIV : LATCH_CYC;
  localparam int PW     = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam logic [PW-1:0] DIV_LAST = PW'(CLK_DIV - 1);
  localparam logic [PW-1:0] LAT_LAST = PW'(LATCH_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    BIT_LO,
    BIT_HI,
    GAP,
    LATCH
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   phase_q, phase_d;
  logic [5:0]      bit_cnt_q, bit_cnt_d;
  logic [31:0]     shreg_q, shreg_d;
  logic            ser_clk_q, ser_clk_d;
  logic            ser_data_q, ser_data_d;
  logic            ser_latch_q, ser_latch_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;

  logic [6:0]      seg_enc [4];
  logic [31:0]     frame_word;

  function automatic logic [6:0] seg7(input logic [3:0] code);
    case (code)
      4'h0:    seg7 = 7'h3F;
      4'h1:    seg7 = 7'h06;
      4'h2:    seg7 = 7'h5B;
      4'h3:    seg7 = 7'h4F;
      4'h4:    seg7 = 7'h66;
      4'h5:    seg7 = 7'h6D;
      4'h6:    seg7 = 7'h7D;
      4'h7:    seg7 = 7'h07;
      4'h8:    seg7 = 7'h7F;
      4'h9:    seg7 = 7'h6F;
      4'hA:    seg7 = 7'h77;
      4'hB:    seg7 = 7'h7C;
      4'hC:    seg7 = 7'h39;
      4'hD:    seg7 = 7'h5E;
      4'hE:    seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  endfunction

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      seg_enc[i] = blank_mask[i] ? 7'h00 : seg7(digits[4*i +: 4]);
    end
    frame_word = raw_mode ? raw_word
                          : {colon, seg_enc[3], 1'b0, seg_enc[2], 1'b0, seg_enc[1], 1'b0, seg_enc[0]};
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ser_clk_d   = ser_clk_q;
    ser_data_d  = ser_data_q;
    ser_latch_d = ser_latch_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = BIT_LO;
          phase_d     = '0;
          bit_cnt_d   = '0;
          shreg_d     = frame_word;
          ser_data_d  = frame_word[31];
          ser_clk_d   = 1'b0;
          ser_latch_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      BIT_LO: begin
        if (phase_q == DIV_LAST) begin
          state_d   = BIT_HI;
          phase_d   = '0;
          ser_clk_d = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      BIT_HI: begin
        if (phase_q == DIV_LAST) begin
          phase_d   = '0;
          shreg_d   = shreg_q << 1;
          ser_clk_d = 1'b0;
          // Data only moves on the falling edge so the receiver sees it stable across the whole high phase.
          if (bit_cnt_q == 6'd31) begin
            state_d    = GAP;
            ser_data_d = 1'b0;
          end else begin
            state_d    = BIT_LO;
            bit_cnt_d  = bit_cnt_q + 6'd1;
            ser_data_d = shreg_q[30];
          end
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      GAP: begin
        if (phase_q == DIV_LAST) begin
          state_d     = LATCH;
          phase_d     = '0;
          ser_latch_d = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      LATCH: begin
        if (phase_q == LAT_LAST) begin
          state_d     = IDLE;
          phase_d     = '0;
          ser_latch_d = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else begin
          phase_d = phase_q + PW'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge osc_clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      ser_clk_q   <= 1'b0;
      ser_data_q  <= 1'b0;
      ser_latch_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ser_clk_q   <= ser_clk_d;
      ser_data_q  <= ser_data_d;
      ser_latch_q <= ser_latch_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign ser_clk   = ser_clk_q;
  assign ser_data  = ser_data_q;
  assign ser_latch = ser_latch_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_seg_frame_tx.sv
// Bench for seg_frame_tx: a receiver model shifts on ser_clk rises and copies on latch rises,
// frames are compared against a table-driven segment encoder.
module tb_seg_frame_tx;

  localparam int D     = 4;
  localparam int LC    = 4;
  localparam int FRAME = 1 + 65*D + LC;

  logic        osc_clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] digits;
  logic        colon;
  logic [3:0]  blank_mask;
  logic        raw_mode;
  logic [31:0] raw_word;
  logic        ser_clk, ser_data, ser_latch, busy, done;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  seg_frame_tx #(.CLK_DIV(D), .LATCH_CYC(LC)) dut (
    .osc_clk   (osc_clk),
    .rst_n     (rst_n),
    .start     (start),
    .digits    (digits),
    .colon     (colon),
    .blank_mask(blank_mask),
    .raw_mode  (raw_mode),
    .raw_word  (raw_word),
    .ser_clk   (ser_clk),
    .ser_data  (ser_data),
    .ser_latch (ser_latch),
    .busy      (busy),
    .done      (done)
  );

  always #5 osc_clk = ~osc_clk;
  always @(posedge osc_clk) cyc <= cyc + 1;

  logic [7:0] seg_tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Receiver model; event times use the "edge that registered it + 1" numbering.
  logic [31:0] rx_sr      = 32'h0;
  logic        prev_clk   = 1'b0;
  logic        prev_data  = 1'b0;
  logic        prev_latch = 1'b0;
  int          rise_t[$];
  logic [31:0] latch_word[$];
  int          latch_rise_t[$];
  int          latch_fall_t[$];
  int          done_t[$];
  int          hi_change = 0;
  int          done_busy = 0;

  always @(negedge osc_clk) begin
    if (ser_clk === 1'b1 && prev_clk !== 1'b1) begin
      rx_sr = {rx_sr[30:0], ser_data};
      rise_t.push_back(cyc + 1);
    end
    if (ser_clk === 1'b1 && prev_clk === 1'b1 && ser_data !== prev_data) hi_change++;
    if (ser_latch === 1'b1 && prev_latch !== 1'b1) begin
      latch_word.push_back(rx_sr);
      latch_rise_t.push_back(cyc + 1);
    end
    if (ser_latch !== 1'b1 && prev_latch === 1'b1) latch_fall_t.push_back(cyc + 1);
    if (done === 1'b1) begin
      done_t.push_back(cyc + 1);
      if (busy !== 1'b0) done_busy++;
    end
    prev_clk   = ser_clk;
    prev_data  = ser_data;
    prev_latch = ser_latch;
  end

  function automatic logic [31:0] ref_frame(input logic [15:0] d, input logic c, input logic [3:0] bm,
                                            input logic rm, input logic [31:0] rw);
    logic [31:0] w;
    int          code;
    if (rm) return rw;
    w = c ? 32'h8000_0000 : 32'h0;
    for (int i = 0; i < 4; i++) begin
      code = (int'(d) >> (4*i)) % 16;
      if (!bm[i]) w = w + (32'(seg_tbl[code]) << (8*i));
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge osc_clk);
    #1;
  endtask

  task automatic run_frame(input string name, input logic [15:0] d, input logic c, input logic [3:0] bm,
                           input logic rm, input logic [31:0] rw, input bit scramble, input bit mid_start);
    int          k, r0, l0, f0, d0, h0, b0, n, bad;
    logic [31:0] exp;
    exp = ref_frame(d, c, bm, rm, rw);
    digits = d; colon = c; blank_mask = bm; raw_mode = rm; raw_word = rw; start = 1'b1;
    r0 = rise_t.size(); l0 = latch_word.size(); f0 = latch_fall_t.size();
    d0 = done_t.size(); h0 = hi_change; b0 = done_busy;
    tick();
    k = cyc;
    start = 1'b0;
    n = 0;
    while (done_t.size() == d0 && n < 2*FRAME) begin
      if (scramble) begin
        digits = 16'($urandom); colon = 1'($urandom); blank_mask = 4'($urandom);
        raw_mode = 1'($urandom); raw_word = $urandom;
      end
      start = (mid_start && cyc == k + 99) ? 1'b1 : 1'b0;
      tick();
      n++;
    end
    start = 1'b0;
    repeat (4) tick();
    check({name, ".done_cnt"}, done_t.size() - d0, 1);
    check({name, ".done_time"}, (done_t.size() > d0) ? done_t[d0] : -1, k + FRAME);
    check({name, ".done_busy"}, done_busy - b0, 0);
    check({name, ".latch_cnt"}, latch_word.size() - l0, 1);
    check({name, ".word"}, (latch_word.size() > l0) ? latch_word[l0] : ~exp, exp);
    check({name, ".latch_rise"}, (latch_rise_t.size() > l0) ? latch_rise_t[l0] : -1, k + 1 + 65*D);
    check({name, ".latch_width"},
          (latch_fall_t.size() > f0 && latch_rise_t.size() > l0) ? latch_fall_t[f0] - latch_rise_t[l0] : -1, LC);
    check({name, ".rise_cnt"}, rise_t.size() - r0, 32);
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      if (rise_t.size() <= r0 + i || rise_t[r0 + i] != k + 1 + D + 2*i*D) bad++;
    end
    check({name, ".rise_times"}, bad, 0);
    check({name, ".hi_stable"}, hi_change - h0, 0);
    check({name, ".idle_after"}, {31'h0, busy}, 0);
  endtask

  initial begin
    int          k0, l0, d0, r0, n, busy_low;
    logic [15:0] da, db, dc;
    logic        cc;
    logic [3:0]  bmv;

    rst_n = 1'b0; start = 1'b0; digits = '0; colon = 1'b0;
    blank_mask = '0; raw_mode = 1'b0; raw_word = '0;
    repeat (3) tick();
    check("reset.ser_clk", {31'h0, ser_clk}, 0);
    check("reset.ser_data", {31'h0, ser_data}, 0);
    check("reset.ser_latch", {31'h0, ser_latch}, 0);
    check("reset.busy", {31'h0, busy}, 0);
    check("reset.done", {31'h0, done}, 0);
    rst_n = 1'b1;
    tick();

    run_frame("t1234", 16'h1234, 1'b1, 4'b0000, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t1234.literal", (latch_word.size() > 0) ? latch_word[$] : 32'h0, 32'h865B4F66);

    run_frame("t0905", 16'h0905, 1'b0, 4'b1000, 1'b0, 32'h0, 1'b0, 1'b0);
    check("t0905.literal", (latch_word.size() > 0) ? latch_word[$] : 32'h0, 32'h006F3F6D);

    run_frame("raw", 16'($urandom), 1'($urandom), 4'($urandom), 1'b1, 32'hA5A5A5A5, 1'b1, 1'b0);
    check("raw.literal", (latch_word.size() > 0) ? latch_word[$] : 32'h0, 32'hA5A5A5A5);

    for (int i = 0; i < 4; i++) begin
      run_frame("rand", 16'($urandom), 1'($urandom), 4'($urandom), 1'b0, $urandom, 1'b0, 1'b0);
    end

    // Back-to-back: start held high across three frames.
    da = 16'($urandom); db = 16'($urandom); dc = 16'($urandom);
    cc = 1'($urandom); bmv = 4'($urandom);
    digits = da; colon = cc; blank_mask = bmv; raw_mode = 1'b0; start = 1'b1;
    l0 = latch_word.size(); d0 = done_t.size();
    tick();
    k0 = cyc;
    digits = db;
    busy_low = 0;
    n = 0;
    while (done_t.size() < d0 + 3 && n < 4*FRAME) begin
      tick();
      n++;
      if (cyc + 1 <= k0 + 3*FRAME - 1 && busy !== 1'b1) busy_low++;
      if (cyc == k0 + FRAME) digits = dc;
      if (cyc == k0 + 2*FRAME) start = 1'b0;
    end
    start = 1'b0;
    check("b2b.done_cnt", done_t.size() - d0, 3);
    check("b2b.busy_low", busy_low, 2);
    for (int j = 0; j < 3; j++) begin
      check("b2b.done_time", (done_t.size() > d0 + j) ? done_t[d0 + j] : -1, k0 + FRAME*(j + 1));
    end
    check("b2b.word0", (latch_word.size() > l0) ? latch_word[l0] : 32'hx, ref_frame(da, cc, bmv, 1'b0, 32'h0));
    check("b2b.word1", (latch_word.size() > l0 + 1) ? latch_word[l0 + 1] : 32'hx, ref_frame(db, cc, bmv, 1'b0, 32'h0));
    check("b2b.word2", (latch_word.size() > l0 + 2) ? latch_word[l0 + 2] : 32'hx, ref_frame(dc, cc, bmv, 1'b0, 32'h0));
    check("b2b.latch_spacing",
          (latch_rise_t.size() > l0 + 2) ? latch_rise_t[l0 + 2] - latch_rise_t[l0 + 1] : -1, FRAME);
    repeat (3) tick();

    // Reset one cycle after the 10th ser_clk rise.
    digits = 16'($urandom); colon = 1'($urandom); blank_mask = 4'($urandom); start = 1'b1;
    r0 = rise_t.size(); l0 = latch_word.size(); d0 = done_t.size();
    tick();
    start = 1'b0;
    n = 0;
    while (rise_t.size() < r0 + 10 && n < 200) begin
      tick();
      n++;
    end
    check("rst.reached_rise10", (rise_t.size() >= r0 + 10) ? 1 : 0, 1);
    rst_n = 1'b0;
    tick();
    check("rst.outputs", {27'h0, ser_clk, ser_data, ser_latch, busy, done}, 0);
    rst_n = 1'b1;
    repeat (2*FRAME) tick();
    check("rst.no_latch", latch_word.size() - l0, 0);
    check("rst.no_done", done_t.size() - d0, 0);
    check("rst.idle", {31'h0, busy}, 0);
    run_frame("after_rst", 16'($urandom), 1'($urandom), 4'($urandom), 1'b0, 32'h0, 1'b0, 1'b0);

    run_frame("mid_start", 16'($urandom), 1'($urandom), 4'($urandom), 1'b0, 32'h0, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
